// File: rtl/cache_pagefault.sv
// cache_pagefault: Sv32 page-fault checker with a one-cycle registered copy of the result.
module cache_pagefault (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         csr_satp_mode_r,
    input  logic         os_csr_mstatus_mprv,
    input  logic         os_csr_mstatus_mxr,
    input  logic         os_csr_mstatus_sum,
    input  logic [1:0]   os_csr_mstatus_mpp,
    input  logic [1:0]   os_csr_mcurrent_privilege,
    input  logic [3:0]   os_cmd,
    input  logic [7:0]   tlb_read_accesstag,
    output logic         pagefault,
    output logic [239:0] reason,
    output logic         pagefault_q,
    output logic [239:0] reason_q
);
    localparam logic [3:0] CMD_LOAD    = 4'd1;
    localparam logic [3:0] CMD_STORE   = 4'd2;
    localparam logic [3:0] CMD_EXECUTE = 4'd3;
    localparam logic [1:0] PRIV_USER    = 2'b00;
    localparam logic [1:0] PRIV_MACHINE = 2'b11;
    logic [1:0]   eff_priv;
    logic         pte_d, pte_a, pte_u, pte_x, pte_w, pte_r, pte_v;
    logic         is_user, is_sup, active;
    logic         pagefault_d;
    logic [239:0] reason_d;
    assign {pte_d, pte_a} = tlb_read_accesstag[7:6];
    assign {pte_u, pte_x, pte_w, pte_r, pte_v} = tlb_read_accesstag[4:0];
    // Effective privilege, decoded privilege class, and whether translation applies.
    always_comb begin
        eff_priv = (os_csr_mcurrent_privilege == PRIV_MACHINE && os_csr_mstatus_mprv && os_cmd != CMD_EXECUTE)
                 ? os_csr_mstatus_mpp : os_csr_mcurrent_privilege;
        is_user  = eff_priv == PRIV_USER;
        is_sup   = !is_user && eff_priv != PRIV_MACHINE;
        active   = csr_satp_mode_r && eff_priv != PRIV_MACHINE;
    end
    // Priority-ordered fault checks; the first matching check names the reason.
    always_comb begin
        pagefault = active;
        reason    = "NONE";
        if (!active)                                                  reason = "NONE";
        else if (!pte_v)                                              reason = "INVALID";
        else if (pte_w && !pte_r)                                     reason = "WRITE_NO_READ";
        else if (!pte_a)                                              reason = "ACCESS_BIT_CLEAR";
        else if (is_user && !pte_u)                                   reason = "USER_ACCESS_SUPERVISOR_PAGE";
        else if (is_sup && pte_u && !os_csr_mstatus_sum)              reason = "SUPERVISOR_USER_PAGE_NO_SUM";
        else if (os_cmd == CMD_EXECUTE && !pte_x)                     reason = "NOT_EXECUTABLE";
        else if (os_cmd == CMD_STORE && !pte_w)                       reason = "NOT_WRITABLE";
        else if (os_cmd == CMD_STORE && !pte_d)                       reason = "DIRTY_BIT_CLEAR";
        else if (os_cmd == CMD_LOAD && !pte_r && !(os_csr_mstatus_mxr && pte_x)) reason = "NOT_READABLE";
        else                                                          pagefault = 1'b0;
    end
    // Next values for the registered copy are simply the current combinational result.
    always_comb begin
        pagefault_d = pagefault;
        reason_d    = reason;
    end
    // Registered copy for downstream stages; cleared to all-zero while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pagefault_q <= 1'b0;
            reason_q    <= '0;
        end else begin
            pagefault_q <= pagefault_d;
            reason_q    <= reason_d;
        end
    end
endmodule

// File: tb/tb_cache_pagefault.sv
// tb_cache_pagefault: directed self-checking bench for cache_pagefault.
module tb_cache_pagefault;
    localparam logic [3:0] C_NONE = 4'd0, C_LOAD = 4'd1, C_STORE = 4'd2, C_EXEC = 4'd3;
    localparam logic [1:0] P_U = 2'b00, P_S = 2'b01, P_R = 2'b10, P_M = 2'b11;
    typedef logic [239:0] str_t;
    typedef struct {
        logic [1:0] priv;
        logic       sum;
        logic       mxr;
        logic [3:0] cmd;
        logic [7:0] tag;
        logic       pf;
        str_t       rs;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         satp = 1'b1, mprv = 1'b0, mxr = 1'b0, sum = 1'b0;
    logic [1:0]   mpp = P_U, priv = P_U;
    logic [3:0]   cmd = C_NONE;
    logic [7:0]   tag = 8'h00;
    logic         pagefault, pagefault_q;
    logic [239:0] reason, reason_q;
    int           passed = 0, total = 0;

    always #5 clk = ~clk;

    cache_pagefault dut (
        .clk(clk), .rst_n(rst_n), .csr_satp_mode_r(satp),
        .os_csr_mstatus_mprv(mprv), .os_csr_mstatus_mxr(mxr), .os_csr_mstatus_sum(sum),
        .os_csr_mstatus_mpp(mpp), .os_csr_mcurrent_privilege(priv), .os_cmd(cmd),
        .tlb_read_accesstag(tag), .pagefault(pagefault), .reason(reason),
        .pagefault_q(pagefault_q), .reason_q(reason_q)
    );

    task automatic drive(input vec_t v);
        priv = v.priv; sum = v.sum; mxr = v.mxr; cmd = v.cmd; tag = v.tag;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        satp = 1'b1; mprv = 1'b0; priv = P_U; cmd = C_LOAD; tag = 8'hDE;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (pagefault_q !== 1'b0 || reason_q !== '0)
            $display("FAIL reset_regs: got pf_q=%b reason_q=%h, need pf_q=0 reason_q=0", pagefault_q, reason_q);
        else passed++;
        total++;
        if (pagefault !== 1'b1 || reason !== str_t'("INVALID"))
            $display("FAIL comb_in_reset: got pf=%b reason=%s, need pf=1 reason=INVALID", pagefault, reason);
        else passed++;
    endtask

    task automatic test_machine();
        priv = P_M; mprv = 1'b0; tag = 8'h10; cmd = C_LOAD;
        for (int i = 0; i < 2; i++) begin
            satp = i[0];
            #1;
            total++;
            if (pagefault !== 1'b0 || reason !== str_t'("NONE"))
                $display("FAIL machine satp=%0d: got pf=%b reason=%s, need pf=0 reason=NONE", i, pagefault, reason);
            else passed++;
        end
        satp = 1'b0; priv = P_U; tag = 8'hDE; #1;
        total++;
        if (pagefault !== 1'b0 || reason !== str_t'("NONE"))
            $display("FAIL bare_user: got pf=%b reason=%s, need pf=0 reason=NONE", pagefault, reason);
        else passed++;
        satp = 1'b1;
    endtask

    task automatic test_mprv();
        vec_t v;
        satp = 1'b1; mprv = 1'b1; mpp = P_U;
        v = '{P_M, 1'b0, 1'b0, C_LOAD, 8'hDE, 1'b1, "INVALID"}; drive(v);
        total++;
        if (pagefault !== v.pf || reason !== v.rs)
            $display("FAIL mprv_load: got pf=%b reason=%s, need pf=%b reason=%s", pagefault, reason, v.pf, v.rs);
        else passed++;
        v = '{P_M, 1'b0, 1'b0, C_EXEC, 8'hDE, 1'b0, "NONE"}; drive(v);
        total++;
        if (pagefault !== v.pf || reason !== v.rs)
            $display("FAIL mprv_exec: got pf=%b reason=%s, need pf=%b reason=%s", pagefault, reason, v.pf, v.rs);
        else passed++;
        mprv = 1'b0;
    endtask

    task automatic test_sup_user_pages();
        vec_t t [6] = '{
            '{P_S, 1'b0, 1'b0, C_NONE,  8'hDF, 1'b1, "SUPERVISOR_USER_PAGE_NO_SUM"},
            '{P_S, 1'b1, 1'b0, C_EXEC,  8'hDF, 1'b0, "NONE"},
            '{P_S, 1'b1, 1'b0, C_LOAD,  8'hDF, 1'b0, "NONE"},
            '{P_S, 1'b1, 1'b0, C_STORE, 8'hDF, 1'b0, "NONE"},
            '{P_R, 1'b0, 1'b0, C_LOAD,  8'hDF, 1'b1, "SUPERVISOR_USER_PAGE_NO_SUM"},
            '{P_U, 1'b0, 1'b0, C_LOAD,  8'hCF, 1'b1, "USER_ACCESS_SUPERVISOR_PAGE"}
        };
        foreach (t[i]) begin
            drive(t[i]);
            total++;
            if (pagefault !== t[i].pf || reason !== t[i].rs)
                $display("FAIL sup_user[%0d]: got pf=%b reason=%s, need pf=%b reason=%s", i, pagefault, reason, t[i].pf, t[i].rs);
            else passed++;
        end
    endtask

    task automatic test_user_perms();
        vec_t t [9] = '{
            '{P_U, 1'b0, 1'b0, C_EXEC,  8'hD7, 1'b1, "NOT_EXECUTABLE"},
            '{P_U, 1'b0, 1'b0, C_EXEC,  8'hD9, 1'b0, "NONE"},
            '{P_U, 1'b0, 1'b0, C_STORE, 8'hDB, 1'b1, "NOT_WRITABLE"},
            '{P_U, 1'b0, 1'b0, C_STORE, 8'hD7, 1'b0, "NONE"},
            '{P_U, 1'b0, 1'b0, C_LOAD,  8'hD9, 1'b1, "NOT_READABLE"},
            '{P_U, 1'b0, 1'b0, C_LOAD,  8'hD3, 1'b0, "NONE"},
            '{P_U, 1'b0, 1'b1, C_LOAD,  8'hD9, 1'b0, "NONE"},
            '{P_U, 1'b0, 1'b0, C_NONE,  8'hD5, 1'b1, "WRITE_NO_READ"},
            '{P_U, 1'b0, 1'b0, C_NONE,  8'hD9, 1'b0, "NONE"}
        };
        foreach (t[i]) begin
            drive(t[i]);
            total++;
            if (pagefault !== t[i].pf || reason !== t[i].rs)
                $display("FAIL user_perm[%0d]: got pf=%b reason=%s, need pf=%b reason=%s", i, pagefault, reason, t[i].pf, t[i].rs);
            else passed++;
        end
    endtask

    task automatic test_dirty_access();
        vec_t t [11] = '{
            '{P_U, 1'b0, 1'b0, C_LOAD,  8'h5F, 1'b0, "NONE"},
            '{P_U, 1'b0, 1'b0, C_STORE, 8'h5F, 1'b1, "DIRTY_BIT_CLEAR"},
            '{P_U, 1'b0, 1'b0, C_EXEC,  8'h5F, 1'b0, "NONE"},
            '{P_U, 1'b0, 1'b0, C_NONE,  8'h9F, 1'b1, "ACCESS_BIT_CLEAR"},
            '{P_U, 1'b0, 1'b0, C_LOAD,  8'h9F, 1'b1, "ACCESS_BIT_CLEAR"},
            '{P_U, 1'b0, 1'b0, C_STORE, 8'h9F, 1'b1, "ACCESS_BIT_CLEAR"},
            '{P_U, 1'b0, 1'b0, C_EXEC,  8'h9F, 1'b1, "ACCESS_BIT_CLEAR"},
            '{P_U, 1'b0, 1'b0, C_LOAD,  8'hDE, 1'b1, "INVALID"},
            '{P_U, 1'b0, 1'b0, C_STORE, 8'hDE, 1'b1, "INVALID"},
            '{P_S, 1'b1, 1'b0, C_EXEC,  8'hDE, 1'b1, "INVALID"},
            '{P_S, 1'b1, 1'b0, C_NONE,  8'hDE, 1'b1, "INVALID"}
        };
        foreach (t[i]) begin
            drive(t[i]);
            total++;
            if (pagefault !== t[i].pf || reason !== t[i].rs)
                $display("FAIL dirty_access[%0d]: got pf=%b reason=%s, need pf=%b reason=%s", i, pagefault, reason, t[i].pf, t[i].rs);
            else passed++;
        end
    endtask

    task automatic test_registers();
        vec_t v;
        @(negedge clk);
        v = '{P_U, 1'b0, 1'b0, C_STORE, 8'hDB, 1'b1, "NOT_WRITABLE"};
        priv = v.priv; sum = v.sum; mxr = v.mxr; cmd = v.cmd; tag = v.tag;
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (pagefault_q !== 1'b1 || reason_q !== v.rs)
            $display("FAIL reg_fault: got pf_q=%b reason_q=%s, need pf_q=1 reason_q=%s", pagefault_q, reason_q, v.rs);
        else passed++;
        @(negedge clk);
        tag = 8'hD7;
        total++;
        if (pagefault_q !== 1'b1)
            $display("FAIL reg_hold_until_edge: got pf_q=%b, need pf_q=1", pagefault_q);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (pagefault_q !== 1'b0 || reason_q !== str_t'("NONE"))
            $display("FAIL reg_clear: got pf_q=%b reason_q=%s, need pf_q=0 reason_q=NONE", pagefault_q, reason_q);
        else passed++;
        @(negedge clk);
        tag = 8'h9F;
        rst_n = 1'b0; #1;
        total++;
        if (pagefault_q !== 1'b0 || reason_q !== '0)
            $display("FAIL reg_async_reset: got pf_q=%b reason_q=%h, need pf_q=0 reason_q=0", pagefault_q, reason_q);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (pagefault_q !== 1'b0 || reason_q !== '0)
            $display("FAIL reg_held_reset: got pf_q=%b reason_q=%h, need pf_q=0 reason_q=0", pagefault_q, reason_q);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (pagefault_q !== 1'b1 || reason_q !== str_t'("ACCESS_BIT_CLEAR"))
            $display("FAIL reg_resume: got pf_q=%b reason_q=%s, need pf_q=1 reason_q=ACCESS_BIT_CLEAR", pagefault_q, reason_q);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_machine();
        test_mprv();
        test_sup_user_pages();
        test_user_perms();
        test_dirty_access();
        test_registers();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
